// File: rtl/text_console_ctrl.sv
// Character-cell console controller: byte-stream writer with cursor and control codes,
// 80x30 character RAM, and a registered read port for the video path.
// Build option: define TEXT_CONSOLE_SCROLL_EN to scroll on newline from the last row
// (otherwise the cursor wraps back to row 0).
module text_console_ctrl #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 30
) (
    input  logic        clk_25mhz,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic [7:0]  char_code,
    output logic [11:0] font_addr,
    output logic        cursor_hit,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);
    localparam int unsigned AW    = 12;
    localparam int unsigned CW    = 7;
    localparam int unsigned RW    = 5;
    localparam int unsigned RW1   = RW + 1;
    localparam int unsigned CELLS = COLS * ROWS;
    localparam logic [7:0]  SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLR_ALL  = 2'd0,
        IDLE     = 2'd1,
        CLR_LINE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   clr_cnt, clr_cnt_n;
    logic [CW-1:0]   col_n;
    logic [RW-1:0]   row_n;
    logic [RW-1:0]   top_row, top_n;
    logic [RW-1:0]   clr_row, clr_row_n;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [7:0]      wdata;
    logic            do_nl;
    logic [RW-1:0]   cur_phys;
    logic [AW-1:0]   cur_addr;
    logic [7:0]      mem [CELLS];

    // Logical-to-physical row fold; inputs never exceed 2*ROWS-1.
    function automatic logic [RW-1:0] wrap_row(input logic [RW1-1:0] r);
        return (r >= RW1'(ROWS)) ? RW'(r - RW1'(ROWS)) : RW'(r);
    endfunction

    function automatic logic [AW-1:0] row_base(input logic [RW-1:0] r);
        return AW'(r) * AW'(COLS);
    endfunction

    assign cur_phys = wrap_row({1'b0, cursor_row} + {1'b0, top_row});
    assign cur_addr = row_base(cur_phys) + AW'(cursor_col);

    // Next-state, cursor and RAM write-port decode.
    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        col_n     = cursor_col;
        row_n     = cursor_row;
        top_n     = top_row;
        clr_row_n = clr_row;
        we        = 1'b0;
        waddr     = '0;
        wdata     = SPACE;
        do_nl     = 1'b0;
        case (state)
            CLR_ALL: begin
                we    = 1'b1;
                waddr = clr_cnt;
                if (clr_cnt == AW'(CELLS - 1)) begin
                    state_n   = IDLE;
                    clr_cnt_n = '0;
                    col_n     = '0;
                    row_n     = '0;
                    top_n     = '0;
                end else begin
                    clr_cnt_n = clr_cnt + AW'(1);
                end
            end
            CLR_LINE: begin
                we    = 1'b1;
                waddr = row_base(clr_row) + clr_cnt;
                if (clr_cnt == AW'(COLS - 1)) begin
                    state_n   = IDLE;
                    clr_cnt_n = '0;
                end else begin
                    clr_cnt_n = clr_cnt + AW'(1);
                end
            end
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        we    = 1'b1;
                        waddr = cur_addr;
                        wdata = in_data;
                        if (cursor_col == CW'(COLS - 1)) begin
                            col_n = '0;
                            do_nl = 1'b1;
                        end else begin
                            col_n = cursor_col + CW'(1);
                        end
                    end else begin
                        case (in_data)
                            8'h0A: begin
                                col_n = '0;
                                do_nl = 1'b1;
                            end
                            8'h0D: col_n = '0;
                            8'h08: begin
                                if (cursor_col != '0) begin
                                    col_n = cursor_col - CW'(1);
                                    we    = 1'b1;
                                    waddr = cur_addr - AW'(1);
                                end
                            end
                            8'h0C: begin
                                state_n   = CLR_ALL;
                                clr_cnt_n = '0;
                            end
                            default: ;
                        endcase
                    end
                    // Newline always ends in a one-row clear of the row the cursor lands on.
                    if (do_nl) begin
                        state_n   = CLR_LINE;
                        clr_cnt_n = '0;
                        if (cursor_row != RW'(ROWS - 1)) begin
                            row_n     = cursor_row + RW'(1);
                            clr_row_n = wrap_row({1'b0, cursor_row} + {1'b0, top_row} + RW1'(1));
                        end else begin
                            clr_row_n = top_row;
`ifdef TEXT_CONSOLE_SCROLL_EN
                            top_n     = wrap_row({1'b0, top_row} + RW1'(1));
`else
                            row_n     = '0;
`endif
                        end
                    end
                end
            end
            default: state_n = CLR_ALL;
        endcase
    end

    // Video read side: cell lookup relative to the current top row.
    logic          in_range;
    logic [CW-1:0] rd_col;
    logic [RW-1:0] rd_row;
    logic [RW-1:0] rd_phys;
    logic [AW-1:0] raddr;
    logic [7:0]    rd_char;

    assign rd_col   = x[9:3];
    assign rd_row   = y[8:4];
    assign in_range = (x < 10'(COLS * 8)) && (y < 10'(ROWS * 16));
    assign rd_phys  = wrap_row({1'b0, rd_row} + {1'b0, top_row});
    assign raddr    = row_base(rd_phys) + AW'(rd_col);
    assign rd_char  = in_range ? mem[raddr] : SPACE;

    always_ff @(posedge clk_25mhz or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLR_ALL;
            clr_cnt    <= '0;
            cursor_col <= '0;
            cursor_row <= '0;
            top_row    <= '0;
            clr_row    <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            char_code  <= SPACE;
            font_addr  <= {SPACE, 4'h0};
            cursor_hit <= 1'b0;
        end else begin
            state      <= state_n;
            clr_cnt    <= clr_cnt_n;
            cursor_col <= col_n;
            cursor_row <= row_n;
            top_row    <= top_n;
            clr_row    <= clr_row_n;
            in_ready   <= (state_n == IDLE);
            busy       <= (state_n != IDLE);
            char_code  <= rd_char;
            font_addr  <= {rd_char, y[3:0]};
            cursor_hit <= in_range && (rd_col == cursor_col) && (rd_row == cursor_row);
        end
    end

    // Character RAM write port; the registered read above sees the old value on a collision.
    always_ff @(posedge clk_25mhz) begin
        if (we && rst_n) begin
            mem[waddr] <= wdata;
        end
    end

endmodule
